// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with input synchroniser, false-start rejection and framing check.
// Define UART_RX_PARITY_EN to compile in the parity bit check (sense selected by PARITY_ODD).
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_bd_tick,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 32 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_cfg: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   data_reg;
    logic                   frame_flag;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
    logic                   par_flag;
`endif

    // Tick counter wraps at mid start bit while in START, at full bit period afterwards.
    logic active_c;
    logic wrap_c;
    logic sample_c;

    always_comb begin
        active_c = (state != S_IDLE) && (state != S_WAIT_IDLE);
        wrap_c   = (state == S_START) ? (tick_cnt == TICK_MID) : (tick_cnt == TICK_LAST);
        sample_c = i_bd_tick && wrap_c;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= S_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            data_reg     <= '0;
            frame_flag   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag     <= 1'b0;
`endif
            o_data       <= '0;
            o_rx_done    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            rx_meta   <= i_rx;
            rx_s      <= rx_meta;
            o_rx_done <= 1'b0;

            if (active_c && i_bd_tick) begin
                tick_cnt <= wrap_c ? '0 : tick_cnt + TW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                        o_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (sample_c) begin
                        if (rx_s) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state      <= S_DATA;
                            bit_cnt    <= '0;
                            frame_flag <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_flag   <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (sample_c) begin
                        data_reg <= {rx_s, data_reg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (sample_c) begin
                        par_flag <= (rx_s != ((^data_reg) ^ PAR_SENSE));
                        state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (sample_c) begin
                        frame_flag <= frame_flag | ~rx_s;
                        if (bit_cnt == STOP_LAST) begin
                            // Report at mid last stop bit so a back-to-back start edge is not missed.
                            bit_cnt      <= '0;
                            o_data       <= data_reg;
                            o_frame_err  <= frame_flag | ~rx_s;
`ifdef UART_RX_PARITY_EN
                            o_parity_err <= par_flag;
`else
                            o_parity_err <= 1'b0;
`endif
                            o_rx_done    <= 1'b1;
                            if (rx_s) begin
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                state  <= S_WAIT_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 32-bit and 8N2 instances share clock, reset and baud tick.
module tb_uart_rx_cfg;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick;
    logic [1:0]  tcnt = 2'd0;
    logic [2:0]  rx = 3'b111;

    logic [7:0]  d8;
    logic [31:0] d32;
    logic [7:0]  d82;
    logic [2:0]  done;
    logic [2:0]  ferr;
    logic [2:0]  perr;
    logic [2:0]  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign tick = (tcnt == 2'(TICK_DIV - 1));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_reset(rst), .i_rx(rx[0]), .i_bd_tick(tick),
        .o_data(d8), .o_rx_done(done[0]), .o_frame_err(ferr[0]),
        .o_parity_err(perr[0]), .o_busy(busy[0])
    );

    uart_rx_cfg #(.DATA_BITS(32), .OVERSAMPLE(16), .STOP_BITS(1)) u_32n1 (
        .i_clk(clk), .i_reset(rst), .i_rx(rx[1]), .i_bd_tick(tick),
        .o_data(d32), .o_rx_done(done[1]), .o_frame_err(ferr[1]),
        .o_parity_err(perr[1]), .o_busy(busy[1])
    );

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)) u_8n2 (
        .i_clk(clk), .i_reset(rst), .i_rx(rx[2]), .i_bd_tick(tick),
        .o_data(d82), .o_rx_done(done[2]), .o_frame_err(ferr[2]),
        .o_parity_err(perr[2]), .o_busy(busy[2])
    );

    // Event monitors: done pulses, back-to-back done cycles, busy rising edges on the 8N1 unit.
    int         done_cnt [3] = '{default: 0};
    int         dbl_cnt      = 0;
    int         busy_rise    = 0;
    logic [2:0] done_q       = 3'b000;
    logic       busy0_q      = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
        if ((done & done_q) != 3'b000) dbl_cnt <= dbl_cnt + 1;
        if (busy[0] && !busy0_q) busy_rise <= busy_rise + 1;
        done_q  <= done;
        busy0_q <= busy[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int line, input logic v);
        rx[line] = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int line, input logic [31:0] data, input int nbits,
                              input logic par, input int nstop, input logic [1:0] stops);
        drive_bit(line, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(line, data[i]);
        if (PAR_EN) drive_bit(line, par);
        for (int i = 0; i < nstop; i++) drive_bit(line, stops[i]);
    endtask

    int n0;
    int n1;
    int n2;
    int b0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data8",  32'(d8),  32'h0);
        check("rst_data32", d32,      32'h0);
        check("rst_done",   32'(done), 32'h0);
        check("rst_ferr",   32'(ferr), 32'h0);
        check("rst_perr",   32'(perr), 32'h0);
        check("rst_busy",   32'(busy), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5
        n0 = done_cnt[0];
        send_frame(0, 32'hA5, 8, 1'b0, 1, 2'b11);
        check("a5_done_cnt", 32'(done_cnt[0] - n0), 32'd1);
        check("a5_data",     32'(d8),      32'hA5);
        check("a5_ferr",     32'(ferr[0]), 32'h0);
        check("a5_perr",     32'(perr[0]), 32'h0);
        check("a5_busy",     32'(busy[0]), 32'h0);

        // 8N1 with low stop bit, then line returns high
        n0 = done_cnt[0];
        send_frame(0, 32'h96, 8, 1'b0, 1, 2'b00);
        drive_bit(0, 1'b1);
        check("fe_done_cnt", 32'(done_cnt[0] - n0), 32'd1);
        check("fe_data",     32'(d8),      32'h96);
        check("fe_ferr",     32'(ferr[0]), 32'h1);
        check("fe_busy",     32'(busy[0]), 32'h0);

        // 32-bit frames back to back
        n1 = done_cnt[1];
        send_frame(1, 32'hDEADBEEF, 32, 1'b0, 1, 2'b11);
        check("w32a_done_cnt", 32'(done_cnt[1] - n1), 32'd1);
        check("w32a_data",     d32, 32'hDEADBEEF);
        send_frame(1, 32'h00000001, 32, 1'b1, 1, 2'b11);
        check("w32b_done_cnt", 32'(done_cnt[1] - n1), 32'd2);
        check("w32b_data",     d32, 32'h00000001);
        check("w32b_ferr",     32'(ferr[1]), 32'h0);

        // Short low glitch in IDLE must be rejected at mid start bit
        n0 = done_cnt[0];
        b0 = busy_rise;
        rx[0] = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("gl_start_seen", 32'(busy_rise - b0), 32'd1);
        check("gl_done_cnt",   32'(done_cnt[0] - n0), 32'd0);
        check("gl_data",       32'(d8),      32'h96);
        check("gl_busy",       32'(busy[0]), 32'h0);

        // 8N2: second stop low, then line held low for three frame times
        n2 = done_cnt[2];
        send_frame(2, 32'h3C, 8, 1'b0, 2, 2'b01);
        rx[2] = 1'b0;
        repeat (3 * 12 * BIT_CLKS) @(negedge clk);
        check("brk_done_cnt", 32'(done_cnt[2] - n2), 32'd1);
        check("brk_data",     32'(d82),     32'h3C);
        check("brk_ferr",     32'(ferr[2]), 32'h1);
        check("brk_busy_low", 32'(busy[2]), 32'h1);
        drive_bit(2, 1'b1);
        check("brk_busy_rel", 32'(busy[2]), 32'h0);
        check("brk_done_rel", 32'(done_cnt[2] - n2), 32'd1);
        send_frame(2, 32'h5A, 8, 1'b0, 2, 2'b11);
        check("n2_done_cnt",  32'(done_cnt[2] - n2), 32'd2);
        check("n2_data",      32'(d82),     32'h5A);
        check("n2_ferr",      32'(ferr[2]), 32'h0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        send_frame(0, 32'h07, 8, 1'b1, 1, 2'b11);
        check("par_ok_data", 32'(d8),      32'h07);
        check("par_ok_perr", 32'(perr[0]), 32'h0);
        send_frame(0, 32'h07, 8, 1'b0, 1, 2'b11);
        check("par_bad_data", 32'(d8),      32'h07);
        check("par_bad_perr", 32'(perr[0]), 32'h1);
        check("par_bad_ferr", 32'(ferr[0]), 32'h0);
`endif

        // Reset in the middle of data bit 4 of 0x55
        n0 = done_cnt[0];
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        rx[0] = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("mr_busy_pre", 32'(busy[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_data", 32'(d8),      32'h0);
        check("mr_done", 32'(done[0]), 32'h0);
        check("mr_ferr", 32'(ferr[0]), 32'h0);
        check("mr_perr", 32'(perr[0]), 32'h0);
        check("mr_busy", 32'(busy[0]), 32'h0);
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("mr_no_done", 32'(done_cnt[0] - n0), 32'd0);
        send_frame(0, 32'h81, 8, 1'b0, 1, 2'b11);
        check("mr81_done_cnt", 32'(done_cnt[0] - n0), 32'd1);
        check("mr81_data",     32'(d8),      32'h81);
        check("mr81_ferr",     32'(ferr[0]), 32'h0);

        check("done_single_cycle", 32'(dbl_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
